// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction fetch stage with prefetch queue
//
// Owns the fetch PC, issues one sequential read at a time to instruction
// memory (req/gnt, then rvalid/rdata) and buffers returned {pc, inst} pairs
// in a DEPTH-entry queue presented to ID with valid/ready. A redirect
// flushes the queue, drops any in-flight response and restarts at a new PC.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_req_o, mem_addr_o    read request and address (= fetch_pc)
//   mem_gnt_i                memory accepts the request this cycle
//   mem_rvalid_i, mem_rdata_i read response
//   redirect_i, redirect_pc_i flush and restart fetch at redirect_pc_i
//   valid_o, ready_i         head-of-queue handshake to ID
//   pc_o, inst_o             head entry (zero when valid_o=0)

module if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];

    logic push;
    logic pop;

    // Redirect targets are word aligned; the low bits are deliberately dropped.
    logic [1:0] unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc_i[1:0];

    always_comb begin
        // Request only with a free slot reserved, so a returning response
        // can always be pushed without checking for full.
        mem_req_o  = !rst && (state == IDLE) && (count < CNT_W'(DEPTH)) && !redirect_i;
        mem_addr_o = fetch_pc;
        valid_o    = (count != '0);
        pc_o       = valid_o ? pc_q[rd_ptr]   : '0;
        inst_o     = valid_o ? inst_q[rd_ptr] : '0;
        push       = (state == BUSY) && mem_rvalid_i && !redirect_i;
        pop        = valid_o && ready_i && !redirect_i;
    end

    // Queue storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= req_pc;
            inst_q[wr_ptr] <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_i) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
            case (state)
                // An outstanding read must still be absorbed before the
                // next request, so BUSY without its response waits in DROP.
                BUSY:    state <= mem_rvalid_i ? IDLE : DROP;
                DROP:    state <= mem_rvalid_i ? IDLE : DROP;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_o && mem_gnt_i) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + ADDR_W'(4);
                        state    <= BUSY;
                    end
                end
                BUSY:    if (mem_rvalid_i) state <= IDLE;
                DROP:    if (mem_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - randomized self-checking bench for if_prefetch

module tb_if_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] inst;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt = 1'b1;
    logic        w_rvalid = 1'b1;
    logic [31:0] w_rdata = '0;
    logic        w_redirect = 1'b0;
    logic [31:0] w_rpc = '0;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_pc;
    logic [31:0] w_inst;

    always #5 clk = ~clk;

    if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .valid_o(valid), .ready_i(ready), .pc_o(pc), .inst_o(inst)
    );

    if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .mem_req_o(w_req), .mem_addr_o(w_addr), .mem_gnt_i(w_gnt),
        .mem_rvalid_i(w_rvalid), .mem_rdata_i(w_rdata),
        .redirect_i(w_redirect), .redirect_pc_i(w_rpc),
        .valid_o(w_valid), .ready_i(w_ready), .pc_o(w_pc), .inst_o(w_inst)
    );

    // Reference model: expected queue contents (PCs; inst is always ~pc),
    // one pending memory read, and the next expected request address.
    logic [31:0] q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];
    bit          pend;
    bit          live;
    bit          stray;
    int          delay;
    logic [31:0] pend_addr;
    logic [31:0] exp_req_pc;
    int          gnt_pct;
    int          dly_min;
    int          dly_max;
    int          cyc;
    int          first_grant;
    int          first_valid;
    int          errors;
    int          checks;

    task automatic cycle();
        bit exp_req;
        bit granted;
        bit popd;
        bit rv;
        mem_gnt    = ($urandom_range(99) < gnt_pct);
        rv         = stray || (pend && delay == 0);
        mem_rvalid = rv;
        mem_rdata  = pend ? ~pend_addr : 32'h1234_5678;
        #1;
        exp_req = !pend && (q.size() < DEPTH) && !redirect;
        checks++;
        if (mem_req !== exp_req) begin
            errors++;
            $display("FAIL mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (mem_addr !== exp_req_pc) begin
                errors++;
                $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_req_pc);
            end
        end
        checks++;
        if (valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid, q.size() != 0);
        end
        checks++;
        if (q.size() != 0) begin
            if (pc !== q[0] || inst !== ~q[0]) begin
                errors++;
                $display("FAIL head cyc=%0d got=%h/%h exp=%h/%h", cyc, pc, inst, q[0], ~q[0]);
            end
        end else if (pc !== 32'h0 || inst !== 32'h0) begin
            errors++;
            $display("FAIL empty_head cyc=%0d got=%h/%h exp=0/0", cyc, pc, inst);
        end
        if (valid === 1'b1 && first_valid < 0) first_valid = cyc;

        granted = exp_req && mem_gnt;
        popd    = (q.size() != 0) && ready && !redirect;
        if (redirect) begin
            q.delete();
            exp_req_pc = redirect_pc & ~32'h3;
        end
        if (popd) begin
            pop_log.push_back(q[0]);
            void'(q.pop_front());
        end
        if (pend) begin
            if (rv) begin
                if (live && !redirect) q.push_back(pend_addr);
                pend = 1'b0;
            end else begin
                delay--;
                if (redirect) live = 1'b0;
            end
        end
        if (granted) begin
            gnt_log.push_back(exp_req_pc);
            if (first_grant < 0) first_grant = cyc;
            pend       = 1'b1;
            live       = 1'b1;
            pend_addr  = exp_req_pc;
            exp_req_pc = exp_req_pc + 32'd4;
            delay      = $urandom_range(dly_max, dly_min);
        end
        stray = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        redirect   = 1'b0;
        ready      = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || valid !== 1'b0 || pc !== 32'h0 || inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs req=%b valid=%b pc=%h inst=%h exp=0", mem_req, valid, pc, inst);
        end
        q.delete();
        gnt_log.delete();
        pop_log.delete();
        pend        = 1'b0;
        live        = 1'b0;
        stray       = 1'b0;
        exp_req_pc  = 32'h0;
        first_grant = -1;
        first_valid = -1;
        cyc         = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_addr !== 32'h0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_addr got=%h/%b exp=0/0", mem_addr, valid);
        end
    endtask

    task automatic test_stream();
        do_reset();
        gnt_pct = 100; dly_min = 0; dly_max = 0; ready = 1'b1;
        for (int i = 0; i < 24; i++) cycle();
        checks++;
        if (first_grant < 0 || first_valid - first_grant != 2) begin
            errors++;
            $display("FAIL latency got=%0d exp=2", first_valid - first_grant);
        end
        checks++;
        if (pop_log.size() < 10 || pop_log[0] !== 32'h0 || pop_log[9] !== 32'h24) begin
            errors++;
            $display("FAIL stream_pops got=%0d exp>=10", pop_log.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        gnt_pct = 100; dly_min = 0; dly_max = 0; ready = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        checks++;
        if (gnt_log.size() != DEPTH || pc !== 32'h0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL full_grants got=%0d pc=%h exp=%0d pc=0", gnt_log.size(), pc, DEPTH);
        end
        ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        checks++;
        if (pop_log.size() < 4 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 ||
            pop_log[2] !== 32'h8 || pop_log[3] !== 32'hC) begin
            errors++;
            $display("FAIL drain_order got=%0d exp=4 in order", pop_log.size());
        end
        checks++;
        if (gnt_log.size() < 5 || gnt_log[4] !== 32'h10) begin
            errors++;
            $display("FAIL resume_addr got=%0d entries exp=0x10 at 5th", gnt_log.size());
        end
    endtask

    task automatic test_redirect_drop();
        int n;
        do_reset();
        gnt_pct = 100; dly_min = 3; dly_max = 3; ready = 1'b1;
        n = 0;
        while (gnt_log.size() == 0 && n < 20) begin cycle(); n++; end
        redirect = 1'b1; redirect_pc = 32'h103;
        cycle();
        redirect = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_empty got=%b exp=0", valid);
        end
        n = 0;
        while (pop_log.size() == 0 && n < 40) begin cycle(); n++; end
        checks++;
        if (gnt_log.size() < 2 || gnt_log[1] !== 32'h100 || pop_log.size() == 0 ||
            pop_log[0] !== 32'h100) begin
            errors++;
            $display("FAIL redirect_restart grants=%0d pops=%0d exp=0x100", gnt_log.size(), pop_log.size());
        end
    endtask

    task automatic test_redirect_rvalid_pop();
        int n;
        int g0;
        do_reset();
        gnt_pct = 100; dly_min = 0; dly_max = 0; ready = 1'b0;
        n = 0;
        while (!(q.size() == 2 && pend && delay == 0) && n < 30) begin cycle(); n++; end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL setup_timeout got=%0d exp<30", n);
        end
        ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        g0 = gnt_log.size();
        cycle();
        redirect = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid got=%b exp=0", valid);
        end
        n = 0;
        while (gnt_log.size() == g0 && n < 20) begin cycle(); n++; end
        checks++;
        if (gnt_log.size() == g0 || gnt_log[g0] !== 32'h200) begin
            errors++;
            $display("FAIL redirect_addr got=%0d grants exp=0x200", gnt_log.size() - g0);
        end
    endtask

    task automatic test_random();
        do_reset();
        gnt_pct = 60; dly_min = 0; dly_max = 3;
        for (int i = 0; i < 400; i++) begin
            ready       = 1'($urandom_range(1));
            redirect    = ($urandom_range(19) == 0);
            redirect_pc = $urandom;
            cycle();
        end
        redirect = 1'b0;
        checks++;
        if (pop_log.size() < 20) begin
            errors++;
            $display("FAIL random_progress got=%0d exp>=20", pop_log.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        #1;
        checks++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", w_req, w_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (w_req !== 1'b0) begin
            errors++;
            $display("FAIL wrap_busy got=%b exp=0", w_req);
        end
        @(posedge clk); #1;
        checks++;
        if (w_req !== 1'b1 || w_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_second got=%b/%h exp=1/0", w_req, w_addr);
        end
    endtask

    task automatic test_reset_busy();
        int n;
        do_reset();
        gnt_pct = 100; dly_min = 5; dly_max = 5; ready = 1'b1;
        n = 0;
        while (!pend && n < 20) begin cycle(); n++; end
        cycle();
        do_reset();
        gnt_pct = 0; ready = 1'b1;
        stray = 1'b1;
        cycle();
        cycle();
        checks++;
        if (valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL stray_rvalid got=%b/%b/%h exp=0/1/0", valid, mem_req, mem_addr);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        gnt_pct = 100;
        dly_min = 0;
        dly_max = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_rvalid_pop();
        test_random();
        test_wrap();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
